// File: rtl/snoop_bus_if.sv
// ---------------------------------------------------------------------------
// snoop_bus_if
// Bus between three processor caches and the snooping bus controller.
//   Request side : req[3], req_op[3][2], req_addr[3][ADDR_W]      (cache -> ctrl)
//   Completion   : ack[3] one-hot strobe, rdata, rshared          (ctrl -> cache)
//   Snoop bcast  : snoop_valid, snoop_op, snoop_addr, snoop_src   (ctrl -> cache)
//   Snoop reply  : snoop_hit[3], snoop_dirty[3], snoop_wdata[3]   (cache -> ctrl)
// The controller connects through the slave modport, the caches (or the
// bench) through the master modport.
// ---------------------------------------------------------------------------
interface snoop_bus_if #(
   parameter int ADDR_W = 5,
   parameter int DATA_W = 8
);
   logic [2:0]                   req;
   logic [2:0][1:0]              req_op;
   logic [2:0][ADDR_W-1:0]       req_addr;
   logic [2:0]                   ack;
   logic [DATA_W-1:0]            rdata;
   logic                         rshared;
   logic                         snoop_valid;
   logic [1:0]                   snoop_op;
   logic [ADDR_W-1:0]            snoop_addr;
   logic [1:0]                   snoop_src;
   logic [2:0]                   snoop_hit;
   logic [2:0]                   snoop_dirty;
   logic [2:0][DATA_W-1:0]       snoop_wdata;

   modport slave (
      input  req, req_op, req_addr, snoop_hit, snoop_dirty, snoop_wdata,
      output ack, rdata, rshared, snoop_valid, snoop_op, snoop_addr, snoop_src
   );

   modport master (
      output req, req_op, req_addr, snoop_hit, snoop_dirty, snoop_wdata,
      input  ack, rdata, rshared, snoop_valid, snoop_op, snoop_addr, snoop_src
   );
endinterface

// File: rtl/snoop_bus_ctrl.sv
// ---------------------------------------------------------------------------
// snoop_bus_ctrl
// Snooping bus controller for three caches sharing one backing memory.
// One transaction at a time: round-robin grant, one-cycle snoop broadcast,
// collect hit/dirty replies, then either take a dirty owner's write-back
// (which also updates memory), read memory, or complete directly.
// Ports:
//   clock    : rising-edge system clock
//   reset_n  : asynchronous active-low reset
//   bus      : snoop_bus_if.slave (requests, completion, snoop broadcast/reply)
// All outputs on bus are driven straight from flops.
// ---------------------------------------------------------------------------
module snoop_bus_ctrl #(
   parameter int ADDR_W = 5,
   parameter int DATA_W = 8
) (
   input  logic        clock,
   input  logic        reset_n,
   snoop_bus_if.slave  bus
);

   localparam int         DEPTH   = 2**ADDR_W;
   localparam logic [1:0] OP_READ = 2'd0;

   typedef enum logic [2:0] {IDLE, SNOOP, COLLECT, WB, MEM, DONE} state_e;

   state_e              state_q, state_d;
   logic [1:0]          id_q, id_d;
   logic [1:0]          op_q, op_d;
   logic [ADDR_W-1:0]   addr_q, addr_d;
   logic [1:0]          last_grant_q, last_grant_d;
   logic                hit_any_q, hit_any_d;
   logic [2:0]          dirty_q, dirty_d;
   logic [DATA_W-1:0]   rdata_q, rdata_d;
   logic [2:0]          ack_q, ack_d;
   logic                snoop_valid_q, snoop_valid_d;
   logic                rshared_q, rshared_d;
   logic [DATA_W-1:0]   mem_q [DEPTH];

   logic                grant_found;
   logic [1:0]          grant_id;
   logic [1:0]          cand;
   logic [2:0]          src_mask;
   logic [2:0]          hit_m;
   logic [2:0]          dirty_m;
   logic [1:0]          wb_id;
   logic [DATA_W-1:0]   wb_data;
   logic                mem_we;

   function automatic logic [1:0] next_idx(input logic [1:0] i);
      return (i == 2'd2) ? 2'd0 : i + 2'd1;
   endfunction

   // Round-robin arbiter: search starts just after the last granted requester.
   always_comb begin
      // NOTE: every variable assigned in always_comb gets a default first so no latch is inferred.
      grant_found = 1'b0;
      grant_id    = 2'd0;
      cand        = next_idx(last_grant_q);
      for (int k = 0; k < 3; k++) begin
         if (!grant_found && bus.req[cand]) begin
            grant_found = 1'b1;
            grant_id    = cand;
         end
         cand = next_idx(cand);
      end
   end

   // The requester's own cache never answers its own snoop.
   assign src_mask = ~(3'b001 << id_q);
   assign hit_m    = bus.snoop_hit   & src_mask;
   assign dirty_m  = bus.snoop_dirty & src_mask;

   // Lowest-index dirty owner supplies the write-back data.
   always_comb begin
      wb_id = 2'd0;
      for (int k = 2; k >= 0; k--) begin
         if (dirty_q[k]) wb_id = 2'(k);
      end
   end

   assign wb_data = bus.snoop_wdata[wb_id];

   always_comb begin
      state_d      = state_q;
      id_d         = id_q;
      op_d         = op_q;
      addr_d       = addr_q;
      last_grant_d = last_grant_q;
      hit_any_d    = hit_any_q;
      dirty_d      = dirty_q;
      rdata_d      = rdata_q;
      mem_we       = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (grant_found) begin
               state_d = SNOOP;
               id_d    = grant_id;
               op_d    = bus.req_op[grant_id];
               addr_d  = bus.req_addr[grant_id];
            end
         end
         SNOOP:   state_d = COLLECT;
         COLLECT: begin
            hit_any_d = |hit_m;
            dirty_d   = dirty_m;
            if (|dirty_m)             state_d = WB;
            else if (op_q == OP_READ) state_d = MEM;
            else                      state_d = DONE;
         end
         WB: begin
            mem_we  = 1'b1;
            rdata_d = wb_data;
            state_d = DONE;
         end
         MEM: begin
            rdata_d = mem_q[addr_q];
            state_d = DONE;
         end
         DONE: begin
            last_grant_d = id_q;
            state_d      = IDLE;
         end
         default: state_d = IDLE;
      endcase

      // Strobes are registered from the next state so they are high exactly
      // during the SNOOP / DONE cycle. A write that leaves COLLECT for DONE is
      // never a read, so the stale hit_any_q there cannot leak into rshared.
      snoop_valid_d = (state_d == SNOOP);
      ack_d         = (state_d == DONE) ? (3'b001 << id_d) : 3'b000;
      rshared_d     = (state_d == DONE) && (op_d == OP_READ) && hit_any_d;
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q       <= IDLE;
         id_q          <= 2'd0;
         op_q          <= 2'd0;
         addr_q        <= '0;
         last_grant_q  <= 2'd2;   // processor 0 wins the first arbitration
         hit_any_q     <= 1'b0;
         dirty_q       <= 3'b000;
         rdata_q       <= '0;
         ack_q         <= 3'b000;
         snoop_valid_q <= 1'b0;
         rshared_q     <= 1'b0;
      end else begin
         // NOTE: state uses non-blocking assignments so all flops update from pre-edge values.
         state_q       <= state_d;
         id_q          <= id_d;
         op_q          <= op_d;
         addr_q        <= addr_d;
         last_grant_q  <= last_grant_d;
         hit_any_q     <= hit_any_d;
         dirty_q       <= dirty_d;
         rdata_q       <= rdata_d;
         ack_q         <= ack_d;
         snoop_valid_q <= snoop_valid_d;
         rshared_q     <= rshared_d;
      end
   end

   // NOTE: the memory is cleared by reset, so it is built from flops rather than a RAM macro.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      end else if (mem_we) begin
         mem_q[addr_q] <= wb_data;
      end
   end

   assign bus.ack         = ack_q;
   assign bus.rdata       = rdata_q;
   assign bus.rshared     = rshared_q;
   assign bus.snoop_valid = snoop_valid_q;
   assign bus.snoop_op    = op_q;
   assign bus.snoop_addr  = addr_q;
   assign bus.snoop_src   = id_q;

endmodule

// File: tb/tb_snoop_bus_ctrl.sv
// ---------------------------------------------------------------------------
// tb_snoop_bus_ctrl
// Directed bench for snoop_bus_ctrl. Inputs change and outputs are sampled
// on the falling edge; cycle numbers count rising edges after a request is
// raised (cycle 1 = SNOOP when the request is granted at once).
// ---------------------------------------------------------------------------
module tb_snoop_bus_ctrl;

   localparam int AW = 5;
   localparam int DW = 8;

   logic clock = 1'b0;
   logic reset_n = 1'b0;
   int   tests = 0;
   int   fails = 0;

   always #5 clock = ~clock;

   snoop_bus_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

   snoop_bus_ctrl #(.ADDR_W(AW), .DATA_W(DW)) dut (
      .clock   (clock),
      .reset_n (reset_n),
      .bus     (bus)
   );

   // Observations gathered by watch().
   int            n_ack, n_sv;
   int            a_cyc [8];
   logic [2:0]    a_val [8];
   logic [DW-1:0] a_rdata [8];
   logic          a_sh [8];
   int            s_cyc [8];
   logic [1:0]    s_src [8];
   logic [1:0]    s_op [8];
   logic [AW-1:0] s_addr [8];

   task automatic clear_inputs();
      bus.req         = 3'b000;
      bus.req_op      = '0;
      bus.req_addr    = '0;
      bus.snoop_hit   = 3'b000;
      bus.snoop_dirty = 3'b000;
      bus.snoop_wdata = '0;
   endtask

   task automatic do_reset();
      @(negedge clock);
      reset_n = 1'b0;
      clear_inputs();
      @(negedge clock);
      @(negedge clock);
      reset_n = 1'b1;
   endtask

   task automatic issue(input int id, input logic [1:0] op, input logic [AW-1:0] addr);
      bus.req_op[id]   = op;
      bus.req_addr[id] = addr;
      bus.req[id]      = 1'b1;
   endtask

   task automatic snoop_resp(input logic [2:0] hit, input logic [2:0] dirty,
                             input logic [DW-1:0] w0, input logic [DW-1:0] w1,
                             input logic [DW-1:0] w2);
      bus.snoop_hit      = hit;
      bus.snoop_dirty    = dirty;
      bus.snoop_wdata[0] = w0;
      bus.snoop_wdata[1] = w1;
      bus.snoop_wdata[2] = w2;
   endtask

   // Runs ncyc cycles recording every snoop strobe and every cycle with ack
   // high. Unless hold is set, an acked requester drops its req at once.
   task automatic watch(input int ncyc, input bit hold);
      n_ack = 0;
      n_sv  = 0;
      for (int i = 0; i < 8; i++) begin
         a_cyc[i] = -1; a_val[i] = 'x; a_rdata[i] = 'x; a_sh[i] = 1'bx;
         s_cyc[i] = -1; s_src[i] = 'x; s_op[i] = 'x; s_addr[i] = 'x;
      end
      for (int c = 1; c <= ncyc; c++) begin
         @(negedge clock);
         if (bus.snoop_valid === 1'b1 && n_sv < 8) begin
            s_cyc[n_sv] = c; s_src[n_sv] = bus.snoop_src;
            s_op[n_sv] = bus.snoop_op; s_addr[n_sv] = bus.snoop_addr;
            n_sv++;
         end
         if (bus.ack !== 3'b000 && n_ack < 8) begin
            a_cyc[n_ack] = c; a_val[n_ack] = bus.ack;
            a_rdata[n_ack] = bus.rdata; a_sh[n_ack] = bus.rshared;
            n_ack++;
            if (!hold) bus.req = bus.req & ~bus.ack;
         end
      end
   endtask

   task automatic test_reset();
      do_reset();
      @(negedge clock);
      tests++; if (bus.ack !== 3'b000) begin fails++; $display("FAIL reset_ack got %b exp 000", bus.ack); end
      tests++; if (bus.snoop_valid !== 1'b0) begin fails++; $display("FAIL reset_snoop_valid got %b exp 0", bus.snoop_valid); end
      tests++; if (bus.rshared !== 1'b0) begin fails++; $display("FAIL reset_rshared got %b exp 0", bus.rshared); end
      tests++; if (bus.rdata !== 8'h00) begin fails++; $display("FAIL reset_rdata got %h exp 00", bus.rdata); end
      tests++; if ({bus.snoop_op, bus.snoop_addr, bus.snoop_src} !== 9'd0) begin fails++;
         $display("FAIL reset_snoop_fields got op %0d addr %0d src %0d exp 0 0 0", bus.snoop_op, bus.snoop_addr, bus.snoop_src); end
   endtask

   task automatic test_read_clean();
      snoop_resp(3'b000, 3'b000, 8'h00, 8'h00, 8'h00);
      issue(0, 2'd0, 5'd5);
      watch(7, 1'b0);
      tests++; if (n_sv !== 1 || s_cyc[0] !== 1) begin fails++; $display("FAIL rd_clean_snoop n %0d cyc %0d exp 1 1", n_sv, s_cyc[0]); end
      tests++; if (s_src[0] !== 2'd0 || s_op[0] !== 2'd0 || s_addr[0] !== 5'd5) begin fails++;
         $display("FAIL rd_clean_snoop_fields got src %0d op %0d addr %0d exp 0 0 5", s_src[0], s_op[0], s_addr[0]); end
      tests++; if (n_ack !== 1 || a_cyc[0] !== 4 || a_val[0] !== 3'b001) begin fails++;
         $display("FAIL rd_clean_ack n %0d cyc %0d val %b exp 1 4 001", n_ack, a_cyc[0], a_val[0]); end
      tests++; if (a_rdata[0] !== 8'h00 || a_sh[0] !== 1'b0) begin fails++;
         $display("FAIL rd_clean_data got rdata %h rshared %b exp 00 0", a_rdata[0], a_sh[0]); end
   endtask

   task automatic test_dirty_writeback();
      // Processor 1 reads 9, cache 2 owns it dirty.
      snoop_resp(3'b100, 3'b100, 8'h00, 8'h00, 8'hA5);
      issue(1, 2'd0, 5'd9);
      watch(7, 1'b0);
      tests++; if (s_src[0] !== 2'd1 || s_cyc[0] !== 1) begin fails++; $display("FAIL wb_rd_snoop got src %0d cyc %0d exp 1 1", s_src[0], s_cyc[0]); end
      tests++; if (n_ack !== 1 || a_cyc[0] !== 4 || a_val[0] !== 3'b010) begin fails++;
         $display("FAIL wb_rd_ack n %0d cyc %0d val %b exp 1 4 010", n_ack, a_cyc[0], a_val[0]); end
      tests++; if (a_rdata[0] !== 8'hA5 || a_sh[0] !== 1'b1) begin fails++;
         $display("FAIL wb_rd_data got rdata %h rshared %b exp a5 1", a_rdata[0], a_sh[0]); end
      // Processor 2 reads 9 back from memory with no hits.
      snoop_resp(3'b000, 3'b000, 8'h00, 8'h00, 8'h00);
      issue(2, 2'd0, 5'd9);
      watch(7, 1'b0);
      tests++; if (n_ack !== 1 || a_cyc[0] !== 4 || a_val[0] !== 3'b100) begin fails++;
         $display("FAIL mem9_ack n %0d cyc %0d val %b exp 1 4 100", n_ack, a_cyc[0], a_val[0]); end
      tests++; if (a_rdata[0] !== 8'hA5 || a_sh[0] !== 1'b0) begin fails++;
         $display("FAIL mem9_data got rdata %h rshared %b exp a5 0", a_rdata[0], a_sh[0]); end
      // Processor 0 write-misses 7; caches 1 and 2 dirty, lowest index wins.
      snoop_resp(3'b110, 3'b110, 8'h00, 8'h5A, 8'hFF);
      issue(0, 2'd1, 5'd7);
      watch(7, 1'b0);
      tests++; if (s_op[0] !== 2'd1 || s_addr[0] !== 5'd7) begin fails++; $display("FAIL wr_wb_snoop got op %0d addr %0d exp 1 7", s_op[0], s_addr[0]); end
      tests++; if (n_ack !== 1 || a_cyc[0] !== 4 || a_val[0] !== 3'b001) begin fails++;
         $display("FAIL wr_wb_ack n %0d cyc %0d val %b exp 1 4 001", n_ack, a_cyc[0], a_val[0]); end
      tests++; if (a_rdata[0] !== 8'h5A || a_sh[0] !== 1'b0) begin fails++;
         $display("FAIL wr_wb_data got rdata %h rshared %b exp 5a 0", a_rdata[0], a_sh[0]); end
   endtask

   task automatic test_invalidate();
      // Processor 2 invalidates 3, cache 0 holds it clean.
      snoop_resp(3'b001, 3'b000, 8'h11, 8'h00, 8'h00);
      issue(2, 2'd2, 5'd3);
      watch(6, 1'b0);
      tests++; if (s_cyc[0] !== 1 || s_op[0] !== 2'd2 || s_src[0] !== 2'd2) begin fails++;
         $display("FAIL inv_snoop got cyc %0d op %0d src %0d exp 1 2 2", s_cyc[0], s_op[0], s_src[0]); end
      tests++; if (n_ack !== 1 || a_cyc[0] !== 3 || a_val[0] !== 3'b100) begin fails++;
         $display("FAIL inv_ack n %0d cyc %0d val %b exp 1 3 100", n_ack, a_cyc[0], a_val[0]); end
      tests++; if (a_rdata[0] !== 8'h5A || a_sh[0] !== 1'b0) begin fails++;
         $display("FAIL inv_hold got rdata %h rshared %b exp 5a 0", a_rdata[0], a_sh[0]); end
      // Write-back of 7 reached memory.
      snoop_resp(3'b000, 3'b000, 8'h00, 8'h00, 8'h00);
      issue(0, 2'd0, 5'd7);
      watch(7, 1'b0);
      tests++; if (n_ack !== 1 || a_rdata[0] !== 8'h5A) begin fails++; $display("FAIL mem7 got n %0d rdata %h exp 1 5a", n_ack, a_rdata[0]); end
      // Op 3 behaves as invalidate: three-cycle completion, rdata held.
      snoop_resp(3'b001, 3'b000, 8'h22, 8'h00, 8'h00);
      issue(1, 2'd3, 5'd3);
      watch(6, 1'b0);
      tests++; if (n_ack !== 1 || a_cyc[0] !== 3 || a_val[0] !== 3'b010 || a_rdata[0] !== 8'h5A) begin fails++;
         $display("FAIL op3_ack n %0d cyc %0d val %b rdata %h exp 1 3 010 5a", n_ack, a_cyc[0], a_val[0], a_rdata[0]); end
      // Memory at 3 never written by the invalidates.
      snoop_resp(3'b000, 3'b000, 8'h00, 8'h00, 8'h00);
      issue(0, 2'd0, 5'd3);
      watch(7, 1'b0);
      tests++; if (n_ack !== 1 || a_rdata[0] !== 8'h00) begin fails++; $display("FAIL mem3 got n %0d rdata %h exp 1 00", n_ack, a_rdata[0]); end
   endtask

   task automatic test_own_dirty();
      snoop_resp(3'b001, 3'b001, 8'h77, 8'h00, 8'h00);
      issue(0, 2'd0, 5'd9);
      watch(7, 1'b0);
      tests++; if (n_ack !== 1 || a_cyc[0] !== 4 || a_val[0] !== 3'b001) begin fails++;
         $display("FAIL own_ack n %0d cyc %0d val %b exp 1 4 001", n_ack, a_cyc[0], a_val[0]); end
      tests++; if (a_rdata[0] !== 8'hA5 || a_sh[0] !== 1'b0) begin fails++;
         $display("FAIL own_data got rdata %h rshared %b exp a5 0", a_rdata[0], a_sh[0]); end
   endtask

   task automatic test_reset_mid();
      // Last completed grant was processor 0; without reset, 1 would win next.
      snoop_resp(3'b001, 3'b001, 8'h3C, 8'h00, 8'h00);
      issue(1, 2'd0, 5'd12);
      @(negedge clock);
      tests++; if (bus.snoop_valid !== 1'b1) begin fails++; $display("FAIL mid_snoop got %b exp 1", bus.snoop_valid); end
      @(negedge clock);                 // COLLECT, dirty owner present
      reset_n = 1'b0;
      #1;
      tests++; if (bus.ack !== 3'b000 || bus.snoop_valid !== 1'b0 || bus.rdata !== 8'h00) begin fails++;
         $display("FAIL mid_reset got ack %b sv %b rdata %h exp 000 0 00", bus.ack, bus.snoop_valid, bus.rdata); end
      clear_inputs();
      @(negedge clock);
      tests++; if (bus.ack !== 3'b000) begin fails++; $display("FAIL mid_no_ack got %b exp 000", bus.ack); end
      reset_n = 1'b1;
      @(negedge clock);
      issue(0, 2'd0, 5'd12);
      issue(1, 2'd0, 5'd12);
      watch(11, 1'b0);
      tests++; if (n_sv !== 2 || s_src[0] !== 2'd0 || s_src[1] !== 2'd1) begin fails++;
         $display("FAIL mid_regrant got n %0d src %0d %0d exp 2 0 1", n_sv, s_src[0], s_src[1]); end
      tests++; if (n_ack !== 2 || a_val[0] !== 3'b001 || a_rdata[0] !== 8'h00) begin fails++;
         $display("FAIL mid_mem got n %0d val %b rdata %h exp 2 001 00", n_ack, a_val[0], a_rdata[0]); end
   endtask

   task automatic test_back_to_back();
      do_reset();
      snoop_resp(3'b000, 3'b000, 8'h00, 8'h00, 8'h00);
      issue(0, 2'd0, 5'd1);
      watch(9, 1'b1);                    // req held through the ack
      bus.req = 3'b000;
      tests++; if (n_ack !== 2 || a_cyc[0] !== 4 || a_cyc[1] !== 9 || a_val[1] !== 3'b001) begin fails++;
         $display("FAIL b2b got n %0d cyc %0d %0d val %b exp 2 4 9 001", n_ack, a_cyc[0], a_cyc[1], a_val[1]); end
      @(negedge clock);
      tests++; if (bus.ack !== 3'b000) begin fails++; $display("FAIL b2b_drop got %b exp 000", bus.ack); end
   endtask

   task automatic test_round_robin();
      logic [2:0] exp_ack [4];
      logic [1:0] exp_src [4];
      exp_ack[0] = 3'b001; exp_ack[1] = 3'b010; exp_ack[2] = 3'b100; exp_ack[3] = 3'b001;
      exp_src[0] = 2'd0;   exp_src[1] = 2'd1;   exp_src[2] = 2'd2;   exp_src[3] = 2'd0;
      do_reset();
      snoop_resp(3'b000, 3'b000, 8'h00, 8'h00, 8'h00);
      issue(0, 2'd0, 5'd2);
      issue(1, 2'd0, 5'd4);
      issue(2, 2'd0, 5'd6);
      watch(19, 1'b1);
      bus.req = 3'b000;
      tests++; if (n_ack !== 4) begin fails++; $display("FAIL rr_count got %0d exp 4", n_ack); end
      for (int i = 0; i < 4; i++) begin
         tests++;
         if (a_val[i] !== exp_ack[i] || a_cyc[i] !== 4 + 5 * i || s_src[i] !== exp_src[i]) begin
            fails++;
            $display("FAIL rr_grant%0d got ack %b cyc %0d src %0d exp %b %0d %0d",
                     i, a_val[i], a_cyc[i], s_src[i], exp_ack[i], 4 + 5 * i, exp_src[i]);
         end
      end
      @(negedge clock);
      tests++; if (bus.ack !== 3'b000) begin fails++; $display("FAIL rr_last_width got %b exp 000", bus.ack); end
   endtask

   initial begin
      clear_inputs();
      test_reset();
      test_read_clean();
      test_dirty_writeback();
      test_invalidate();
      test_own_dirty();
      test_reset_mid();
      test_back_to_back();
      test_round_robin();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
